// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of the word-addressed data RAM interface. Accepts one
//   byte/halfword/word load or store at a time from the load/store stage,
//   performs lane selection with sign/zero extension for loads, and a
//   read-modify-write sequence for byte and halfword stores.
//
// Ports
//   clk, clr              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_funct3            RISC-V size/sign encoding
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              access rejected (qualifies resp_valid)
//   mem_address           word index (latched address >> 2)
//   mem_read, mem_write   one-cycle RAM strobes, never together
//   mem_datain            word written to the RAM
//   mem_dataout           RAM read data, valid the cycle after mem_read
//
// Build option
//   MEM_BOUND_CHECK_EN    when defined, word indices >= MEM_WORDS are
//                         rejected as errors without any RAM strobe.

module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_RMW_RD,
    S_RMW_MRG,
    S_WR,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_datain_q;

  // Request decode, evaluated only while idle.
  logic illegal_d;
  logic misalign_d;
  logic oob_d;
  logic err_d;

  always_comb begin
    illegal_d  = 1'b0;
    misalign_d = 1'b0;
    if (req_we) begin
      illegal_d = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                    req_funct3 == 3'b010);
    end else begin
      illegal_d = (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                   req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   misalign_d = req_addr[0];
      2'b10:   misalign_d = (req_addr[1:0] != 2'b00);
      default: misalign_d = 1'b0;
    endcase
`ifdef MEM_BOUND_CHECK_EN
    oob_d = ({2'b00, req_addr[31:2]} >= unsigned'(MEM_WORDS));
`else
    oob_d = 1'b0;
`endif
    err_d = illegal_d | misalign_d | oob_d;
  end

  // Load lane select / extension and store merge, both working on the
  // RAM word that arrives the cycle after the read strobe.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    byte_sel = mem_dataout[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_dataout[31:16] : mem_dataout[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = mem_dataout;
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = '0;
    endcase

    merged = mem_dataout;
    if (funct3_q[0]) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Outputs are registered on the edge that enters the state they belong
  // to, so every strobe lines up with its state and nothing depends
  // combinationally on the request inputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_IDLE;
      lane_q        <= '0;
      funct3_q      <= '0;
      wdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_datain_q  <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            lane_q        <= req_addr[1:0];
            funct3_q      <= req_funct3;
            wdata_q       <= req_wdata[15:0];
            mem_address_q <= {2'b00, req_addr[31:2]};
            resp_rdata_q  <= '0;
            if (err_d) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we) begin
              state_q    <= S_RD;
              mem_read_q <= 1'b1;
            end else if (req_funct3 == 3'b010) begin
              state_q      <= S_WR;
              mem_write_q  <= 1'b1;
              mem_datain_q <= req_wdata;
            end else begin
              state_q    <= S_RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        S_RD: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          resp_rdata_q <= load_ext;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_RMW_RD: begin
          state_q <= S_RMW_MRG;
        end
        S_RMW_MRG: begin
          mem_datain_q <= merged;
          mem_write_q  <= 1'b1;
          state_q      <= S_WR;
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_datain  = mem_datain_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_address(mem_address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_datain (mem_datain),
    .mem_dataout(mem_dataout)
  );

  // Attached RAM: synchronous read, data valid the cycle after mem_read.
  logic [31:0] ram [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  always @(posedge clk) begin
    if (mem_read)  mem_dataout <= ram[mem_address[9:0]];
    if (mem_write) ram[mem_address[9:0]] <= mem_datain;
    if (poke_en)   ram[poke_addr] <= poke_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // One full transaction; exp_*_k are the cycles after accept at which the
  // strobes must appear (0 = never).
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_rd_k, input int exp_wr_k,
                         input logic [31:0] exp_wdat);
    int          lat  = 0;
    int          rd_k = 0;
    int          wr_k = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] rd_a = '0;
    logic [31:0] wr_a = '0;
    logic [31:0] wr_d = '0;
    logic [31:0] rdat = '0;
    logic        err  = 1'b0;
    logic        both = 1'b0;
    logic [31:0] widx;
    widx = {2'b00, addr[31:2]};
    @(negedge clk);
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hFFFF_FFFF;
    for (int k = 1; k <= 10; k++) begin
      if (mem_read) begin
        n_rd++;
        if (rd_k == 0) begin rd_k = k; rd_a = mem_address; end
      end
      if (mem_write) begin
        n_wr++;
        if (wr_k == 0) begin wr_k = k; wr_a = mem_address; wr_d = mem_datain; end
      end
      if (mem_read && mem_write) both = 1'b1;
      if (resp_valid) begin
        lat  = k;
        rdat = resp_rdata;
        err  = resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, rdat, exp_rdata);
    check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, " rd_cycle"}, rd_k, exp_rd_k);
    check({tag, " rd_count"}, n_rd, (exp_rd_k != 0) ? 1 : 0);
    check({tag, " wr_cycle"}, wr_k, exp_wr_k);
    check({tag, " wr_count"}, n_wr, (exp_wr_k != 0) ? 1 : 0);
    check({tag, " rd_wr_overlap"}, {31'b0, both}, 32'd0);
    if (exp_rd_k != 0) check({tag, " rd_addr"}, rd_a, widx);
    if (exp_wr_k != 0) begin
      check({tag, " wr_addr"}, wr_a, widx);
      check({tag, " wr_data"}, wr_d, exp_wdat);
    end
    @(posedge clk);
    #1;
    check({tag, " resp_pulse_end"}, {31'b0, resp_valid}, 32'd0);
    check({tag, " ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_wr;
    logic seen_rv;
    clr        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_err", {31'b0, resp_err}, 32'd0);
    check("rst mem_read", {31'b0, mem_read}, 32'd0);
    check("rst mem_write", {31'b0, mem_write}, 32'd0);
    check("rst mem_address", mem_address, 32'd0);
    check("rst mem_datain", mem_datain, 32'd0);
    check("rst ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    clr = 1'b0;

    poke(10'd0,    32'h0BAD_F00D);
    poke(10'd1023, 32'h1357_9BDF);

    // Word store then load
    run_req("sw",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEAD_BEEF);
    run_req("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0, 32'h0);

    // Sub-word read-modify-write
    run_req("sb",  1'b1, 3'b000, 32'h12, 32'hAAAA_AA55, 32'h0, 1'b0, 4, 1, 3, 32'hDE55_BEEF);
    run_req("sh",  1'b1, 3'b001, 32'h10, 32'hFFFF_1234, 32'h0, 1'b0, 4, 1, 3, 32'hDE55_1234);
    run_req("lw2", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE55_1234, 1'b0, 3, 1, 0, 32'h0);

    // Extension
    poke(10'd4, 32'h80F0_FF7F);
    run_req("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFFF, 1'b0, 3, 1, 0, 32'h0);
    run_req("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_00FF, 1'b0, 3, 1, 0, 32'h0);
    run_req("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_80F0, 1'b0, 3, 1, 0, 32'h0);
    run_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_80F0, 1'b0, 3, 1, 0, 32'h0);
    run_req("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_007F, 1'b0, 3, 1, 0, 32'h0);
    run_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1, 0, 32'h0);
    run_req("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_FF7F, 1'b0, 3, 1, 0, 32'h0);

    // Errors
    run_req("lw_mis",  1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    run_req("sh_mis",  1'b1, 3'b001, 32'h13, 32'h1234, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    run_req("ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    run_req("st_f100", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    run_req("lw_ok",   1'b0, 3'b010, 32'h10, 32'h0, 32'h80F0_FF7F, 1'b0, 3, 1, 0, 32'h0);

    // Reset during RMW merge of SB 0x12
    poke(10'd4, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h12;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("mid_rst ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst mem_write", {31'b0, mem_write}, 32'd0);
    check("mid_rst mem_read", {31'b0, mem_read}, 32'd0);
    check("mid_rst mem_address", mem_address, 32'd0);
    check("mid_rst mem_datain", mem_datain, 32'd0);
    check("mid_rst resp_rdata", resp_rdata, 32'd0);
    seen_wr = 1'b0;
    seen_rv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (mem_write)  seen_wr = 1'b1;
      if (resp_valid) seen_rv = 1'b1;
      @(posedge clk);
      #1;
    end
    check("mid_rst no_write", {31'b0, seen_wr}, 32'd0);
    check("mid_rst no_resp", {31'b0, seen_rv}, 32'd0);
    check("mid_rst ram_kept", ram[4], 32'hDEAD_BEEF);

    // Top of RAM and beyond
    run_req("lw_top", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h1357_9BDF, 1'b0, 3, 1, 0, 32'h0);
`ifdef MEM_BOUND_CHECK_EN
    run_req("lw_oob", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
`else
    run_req("lw_wrap", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1, 0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
